// File: rtl/simon_seq_pkg.sv
// Shared definitions for the Simon-128/128 block sequencer: register map,
// CSR bit positions, mode encodings and the sequencer state type.
package simon_seq_pkg;

    // Register byte addresses; word n of a 128-bit field lives at base + 4n
    localparam logic [7:0] ADDR_PT0  = 8'h00;
    localparam logic [7:0] ADDR_KEY0 = 8'h10;
    localparam logic [7:0] ADDR_CT0  = 8'h20;
    localparam logic [7:0] ADDR_CSR  = 8'h30;
    localparam logic [7:0] ADDR_MODE = 8'h34;

    // CSR bits: start is write-only, valid is read-only
    localparam int CSR_START = 0;
    localparam int CSR_VALID = 1;

    localparam logic MODE_ENC = 1'b1;
    localparam logic MODE_DEC = 1'b0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_MODE,
        ST_WR_KEY,
        ST_WR_PT,
        ST_START,
        ST_POLL,
        ST_RD_CT,
        ST_RD_CAP,
        ST_OUT
    } simon_seq_state_t;

    // Select 32-bit word idx of a 128-bit block (word 0 least significant)
    function automatic logic [31:0] word_sel(input logic [127:0] blk, input logic [1:0] idx);
        return blk[{idx, 5'b0} +: 32];
    endfunction

endpackage

// File: rtl/simon_block_sequencer.sv
// Autonomous bus master for the Simon-128/128 register interface.
// Per block: MODE write, KEY writes (only when the key changed), PT writes,
// START, CSR poll, CT reads, then the result is offered on the output stream.
// Optional feature macro: SIMON_SEQ_TIMEOUT_EN -- aborts a poll that sees no
// valid within TIMEOUT_CYCLES reads and reports out_err_o with zero data.
module simon_block_sequencer
    import simon_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_i,
    input  logic         key_load_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] in_data_i,
    input  logic         in_mode_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] out_data_o,
    output logic         out_err_o,
    output logic         en_o,
    output logic [3:0]   we_o,
    output logic [7:0]   addr_o,
    output logic [31:0]  wdata_o,
    input  logic [31:0]  rdata_i
);

    simon_seq_state_t state_q, state_d;
    logic [127:0] key_q, key_d;
    logic         key_ok_q, key_ok_d;
    logic         dirty_q, dirty_d;
    logic         use_key_q, use_key_d;
    logic         mode_q, mode_d;
    logic [127:0] pt_q, pt_d;
    logic [127:0] ct_q, ct_d;
    // Word index shared by WR_KEY, WR_PT and RD_CT; in POLL it doubles as a
    // saturating response counter so the first returned word is skipped.
    logic [1:0]   idx_q, idx_d;
    logic [1:0]   cap_idx;
    logic         accept;
    logic         timeout_hit;

`ifdef SIMON_SEQ_TIMEOUT_EN
    localparam int POLL_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [POLL_CNT_W-1:0] POLL_LAST = POLL_CNT_W'(TIMEOUT_CYCLES - 1);
    logic [POLL_CNT_W-1:0] poll_cnt_q, poll_cnt_d;
    logic                  err_q, err_d;
`endif

    assign accept      = in_valid_i && in_ready_o;
    assign cap_idx     = idx_q - 2'd1;
    assign in_ready_o  = key_ok_q && (state_q == ST_IDLE);
    assign out_valid_o = (state_q == ST_OUT);
    assign out_data_o  = ct_q;
`ifdef SIMON_SEQ_TIMEOUT_EN
    assign out_err_o   = err_q;
`else
    assign out_err_o   = 1'b0;
`endif

    // State and datapath registers; reset drops any in-flight block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            key_q      <= '0;
            key_ok_q   <= 1'b0;
            dirty_q    <= 1'b0;
            use_key_q  <= 1'b0;
            mode_q     <= 1'b0;
            pt_q       <= '0;
            ct_q       <= '0;
            idx_q      <= '0;
`ifdef SIMON_SEQ_TIMEOUT_EN
            poll_cnt_q <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            key_ok_q   <= key_ok_d;
            dirty_q    <= dirty_d;
            use_key_q  <= use_key_d;
            mode_q     <= mode_d;
            pt_q       <= pt_d;
            ct_q       <= ct_d;
            idx_q      <= idx_d;
`ifdef SIMON_SEQ_TIMEOUT_EN
            poll_cnt_q <= poll_cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    // Next-state and datapath update for the register transaction sequence
    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        key_ok_d    = key_ok_q;
        dirty_d     = dirty_q;
        use_key_d   = use_key_q;
        mode_d      = mode_q;
        pt_d        = pt_q;
        ct_d        = ct_q;
        idx_d       = idx_q;
        timeout_hit = 1'b0;
`ifdef SIMON_SEQ_TIMEOUT_EN
        poll_cnt_d  = poll_cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    pt_d      = in_data_i;
                    mode_d    = in_mode_i;
                    use_key_d = dirty_q;
                    dirty_d   = 1'b0;
                    ct_d      = '0;
                    idx_d     = '0;
`ifdef SIMON_SEQ_TIMEOUT_EN
                    err_d     = 1'b0;
`endif
                    state_d   = ST_WR_MODE;
                end
            end
            ST_WR_MODE: begin
                state_d = use_key_q ? ST_WR_KEY : ST_WR_PT;
            end
            ST_WR_KEY: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = ST_WR_PT;
                end
            end
            ST_WR_PT: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                idx_d = '0;
`ifdef SIMON_SEQ_TIMEOUT_EN
                poll_cnt_d = '0;
`endif
                state_d = ST_POLL;
            end
            ST_POLL: begin
                if (idx_q != 2'd2) begin
                    idx_d = idx_q + 2'd1;
                end
`ifdef SIMON_SEQ_TIMEOUT_EN
                poll_cnt_d = poll_cnt_q + 1'b1;
`endif
                // idx_q==2 means rdata_i answers the second or a later poll
                if ((idx_q == 2'd2) && rdata_i[CSR_VALID]) begin
                    idx_d   = '0;
                    state_d = ST_RD_CT;
                end
`ifdef SIMON_SEQ_TIMEOUT_EN
                else if (poll_cnt_q == POLL_LAST) begin
                    idx_d       = '0;
                    err_d       = 1'b1;
                    timeout_hit = 1'b1;
                    state_d     = ST_OUT;
                end
`endif
            end
            ST_RD_CT: begin
                idx_d = idx_q + 2'd1;
                if (idx_q != 2'd0) begin
                    ct_d[{cap_idx, 5'b0} +: 32] = rdata_i;
                end
                if (idx_q == 2'd3) begin
                    state_d = ST_RD_CAP;
                end
            end
            ST_RD_CAP: begin
                ct_d[96 +: 32] = rdata_i;
                state_d        = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A timed-out core is in an unknown state, so force a key rewrite
        if (timeout_hit) begin
            dirty_d = 1'b1;
        end
        // Key load overrides the accept-time clear so it lands on the next block
        if (key_load_i) begin
            key_d    = key_i;
            key_ok_d = 1'b1;
            dirty_d  = 1'b1;
        end
    end

    // Bus outputs decoded from the current state and word index
    always_comb begin
        en_o    = 1'b0;
        we_o    = 4'h0;
        addr_o  = 8'h00;
        wdata_o = 32'h0;
        case (state_q)
            ST_WR_MODE: begin
                en_o    = 1'b1;
                we_o    = 4'hF;
                addr_o  = ADDR_MODE;
                wdata_o = {31'b0, mode_q};
            end
            ST_WR_KEY: begin
                en_o    = 1'b1;
                we_o    = 4'hF;
                addr_o  = ADDR_KEY0 + {4'b0, idx_q, 2'b00};
                wdata_o = word_sel(key_q, idx_q);
            end
            ST_WR_PT: begin
                en_o    = 1'b1;
                we_o    = 4'hF;
                addr_o  = ADDR_PT0 + {4'b0, idx_q, 2'b00};
                wdata_o = word_sel(pt_q, idx_q);
            end
            ST_START: begin
                en_o    = 1'b1;
                we_o    = 4'hF;
                addr_o  = ADDR_CSR;
                wdata_o = 32'h1 << CSR_START;
            end
            ST_POLL: begin
                en_o   = 1'b1;
                addr_o = ADDR_CSR;
            end
            ST_RD_CT: begin
                en_o   = 1'b1;
                addr_o = ADDR_CT0 + {4'b0, idx_q, 2'b00};
            end
            default: begin
                en_o    = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/simon_block_sequencer.md
# simon_block_sequencer

Bus-master controller that drives the Simon-128/128 register interface autonomously. It accepts 128-bit blocks on a valid/ready stream and performs the full register transaction for each block. It writes MODE, writes the KEY words only when the key has changed, writes PT, starts the core, polls CSR.valid, reads CT, and returns the result on an output stream. It sits between a software/DMA front end and the existing memory-mapped Simon interface, so the processor no longer bit-bangs registers.

## Interface
- TIMEOUT_CYCLES, 255: maximum number of CSR poll reads before abort (used only with the timeout feature).
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- key_i  in  128  key; bits [31:0] map to KEY_0 at 0x10
- key_load_i  in  1  one-cycle pulse; captures key_i and marks the key dirty
- in_valid_i / in_ready_o  in/out  1  input block handshake
- in_data_i  in  128  PT/CT block; bits [31:0] map to 0x00
- in_mode_i  in  1  1 = encrypt, 0 = decrypt
- out_valid_o / out_ready_i  out/in  1  result handshake
- out_data_o  out  128  result; bits [31:0] come from 0x20
- out_err_o  out  1  timeout flag, qualified by out_valid_o
- en_o  out  1  bus enable to the interface
- we_o  out  4  byte write enables; either 4'hF (write) or 4'h0 (read)
- addr_o  out  8  register byte address
- wdata_o  out  32  write data
- rdata_i  in  32  registered read data; valid the cycle after a read is issued

## Operation
- Register map: PT 0x00–0x0C; KEY 0x10–0x1C; CT 0x20–0x2C; CSR 0x30 (bit0 start on write, bit1 valid on read); MODE 0x34. Word n is at base+4n, with word 0 least significant.
- key_ok is set by key_load_i and cleared only by reset. in_ready_o = key_ok && state==IDLE.
- key_load_i stores key_i and sets dirty. If dirty is set and cleared in the same cycle, set wins. A load coinciding with an accept applies to the next block.
- State sequence:
  - IDLE: on accept, latch in_data_i and in_mode_i, snapshot dirty into use_key, clear dirty → WR_MODE.
  - WR_MODE: write 0x34 = {31'b0, mode} for 1 cycle → WR_KEY if use_key, else WR_PT.
  - WR_KEY: 4 writes to 0x10–0x1C → WR_PT.
  - WR_PT: 4 writes to 0x00–0x0C → START.
  - START: write 0x30 = 1 → POLL.
  - POLL: read 0x30 every cycle. Ignore the first returned word. When any later rdata_i[1]==1 → RD_CT.
  - RD_CT: issue reads 0x20, 0x24, 0x28, 0x2C on consecutive cycles and capture each word the following cycle → OUT.
  - OUT: hold out_valid_o with stable out_data_o/out_err_o until out_ready_i → IDLE.
- Outside bus cycles: en_o=0, we_o=0, addr_o=0, wdata_o=0.
- Reset, including mid-operation: every output returns to 0, the FSM goes to IDLE, and key_ok/dirty clear. The in-flight block is dropped.

## Timing
- Reset values: in_ready_o=0, out_valid_o=0, out_err_o=0, out_data_o=0, en_o=0, we_o=0, addr_o=0, wdata_o=0.
- Accept at edge 0. Clean key: bus cycles 1–6 are MODE, PT×4, START. Dirty key: cycles 1–10.
- Poll reads start the cycle after START. If valid is seen on poll response k, CT reads take 4 issue cycles plus 1 capture cycle. out_valid_o then rises the following cycle.
- Minimum block-to-block occupancy with a clean key and instant out_ready_i: 6 + poll + 6 cycles.
- in_ready_o is low from accept until the OUT handshake completes. There is no overlap between blocks.

## Configuration
- SIMON_SEQ_TIMEOUT_EN defined:
  - POLL counts issued reads.
  - After TIMEOUT_CYCLES reads without valid → OUT with out_err_o=1 and out_data_o=0.
  - The next block forces a key rewrite (dirty set).
- SIMON_SEQ_TIMEOUT_EN undefined:
  - POLL waits indefinitely.
  - out_err_o is tied to 0.
  - The counter is not synthesized.

## Structure
- Shared package simon_seq_pkg holds:
  - register address localparams (ADDR_PT0, ADDR_KEY0, ADDR_CT0, ADDR_CSR, ADDR_MODE)
  - CSR bit indices (CSR_START, CSR_VALID)
  - MODE_ENC / MODE_DEC
  - state enum type simon_seq_state_t
- Single module with no sub-module. A 2-bit word index counter is shared by WR_KEY, WR_PT and RD_CT.

## Test plan
- Encrypt with the standard vector:
  - Stimulus: key 0x0F0E0D0C_0B0A0908_07060504_03020100, PT 0x63736564_20737265_6c6c6576_61727420, mode 1.
  - Response: out_data_o = 0x49681b1e_1e54fe3f_65aa832a_f84e0bbc. Bus trace shows MODE, KEY×4, PT×4, START in order.
- Second block with the same key and no key_load_i:
  - Response: no writes to 0x10–0x1C; exactly 6 write cycles precede the first poll.
- Decrypt:
  - Stimulus: in_data_i = 0x49681b1e_1e54fe3f_65aa832a_f84e0bbc, mode 0.
  - Response: out_data_o = 0x63736564_20737265_6c6c6576_61727420.
- Backpressure and key load during operation:
  - Stimulus: hold out_ready_i=0 for 10 cycles, and pulse key_load_i during POLL.
  - Response: out_data_o is stable and in_ready_o=0 throughout. The next block rewrites KEY.
- Timeout (SIMON_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16):
  - Stimulus: stub interface never sets valid.
  - Response: after 16 polls, out_valid_o=1, out_err_o=1, out_data_o=0.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during WR_PT.
  - Response: all outputs are 0 immediately. in_ready_o stays 0 until a new key_load_i.
